// File: rtl/fft16_agu.sv
// ---------------------------------------------------------------------------
// fft16_agu -- address generator / sequencer for a 16-point radix-2 DIT FFT.
//
// Walks 4 stages x 8 butterflies, 8 cycles per butterfly, with no bubbles.
// It feeds the butterfly operands in its fixed order (br, wr, bi, wi, ar, ai)
// from an asynchronous-read data RAM and twiddle ROM. It commits each
// butterfly's four results (r1r, r1i, r2r, r2i) back in place. The last two
// results are written during the first two cycles of the next butterfly, or
// during FLUSH after the final butterfly.
//
// Ports
//   xClock        in   system clock, rising edge
//   xReset        in   synchronous active-high reset
//   xStart        in   start request, honoured only in IDLE
//   rd_addr       out  data RAM read address {point, im}
//   tw_addr       out  twiddle ROM address {k, im}
//   src_tw        out  butterfly input mux: 1 = twiddle ROM, 0 = data RAM
//   wr_addr       out  data RAM write address {point, im}
//   we            out  data RAM write enable
//   c_output_tri  out  butterfly output tristate control (~we)
//   bf_start      out  butterfly start pulse (first cycle of a run)
//   bf_reset      out  butterfly reset (xReset or DONE)
//   busy          out  high in RUN and FLUSH
//   done          out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module fft16_agu #(
    parameter int LOG2N = 4
) (
    input  logic             xClock,
    input  logic             xReset,
    input  logic             xStart,
    output logic [LOG2N:0]   rd_addr,
    output logic [LOG2N-1:0] tw_addr,
    output logic             src_tw,
    output logic [LOG2N:0]   wr_addr,
    output logic             we,
    output logic             c_output_tri,
    output logic             bf_start,
    output logic             bf_reset,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  s_q, s_d;          // stage
    logic [2:0]  j_q, j_d;          // butterfly within stage
    logic [2:0]  c_q, c_d;          // slot cycle; doubles as the flush index in FLUSH
    logic [3:0]  b_prev_q, b_prev_d;

    // Butterfly geometry for the current (s, j).
    logic [3:0] span, jx, jlo, a_pt, b_pt;
    logic [2:0] k;
    logic       first_bf;

    always_comb begin
        span     = 4'd1 << s_q;
        jx       = {1'b0, j_q};
        jlo      = jx & (span - 4'd1);
        // Group index times 2*span, written as masking off the low bits and
        // doubling, so the shift never needs a wider amount than s_q.
        a_pt     = ((jx & ~(span - 4'd1)) << 1) + jlo;
        b_pt     = a_pt + span;
        k        = jlo[2:0] << (2'd3 - s_q);
        first_bf = (s_q == 2'd0) && (j_q == 3'd0);
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        s_d      = s_q;
        j_d      = j_q;
        c_d      = c_q;
        b_prev_d = b_prev_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xStart) begin
                    state_d = ST_RUN;
                    s_d     = 2'd0;
                    j_d     = 3'd0;
                    c_d     = 3'd0;
                end
            end
            ST_RUN: begin
                c_d = c_q + 3'd1;
                if (c_q == 3'd7) begin
                    b_prev_d = b_pt;
                    j_d      = j_q + 3'd1;
                    if (j_q == 3'd7) begin
                        s_d = s_q + 2'd1;
                        // All counters wrap to 0 here, so FLUSH starts at fl=0.
                        if (s_q == 2'd3) state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                c_d = c_q + 3'd1;
                if (c_q[0]) begin
                    state_d = ST_DONE;
                    c_d     = 3'd0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge xClock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (xReset) begin
            state_q  <= ST_IDLE;
            s_q      <= 2'd0;
            j_q      <= 3'd0;
            c_q      <= 3'd0;
            b_prev_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            j_q      <= j_d;
            c_q      <= c_d;
            b_prev_q <= b_prev_d;
        end
    end

    // Moore output decode.
    always_comb begin
        rd_addr  = '0;
        tw_addr  = '0;
        src_tw   = 1'b0;
        wr_addr  = '0;
        we       = 1'b0;
        bf_start = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                bf_start = first_bf && (c_q == 3'd0);
                unique case (c_q)
                    3'd0: begin
                        rd_addr = {b_pt, 1'b0};
                        // Tail writes of the previous butterfly; none before the first.
                        we      = !first_bf;
                        wr_addr = first_bf ? '0 : {b_prev_q, 1'b0};
                    end
                    3'd1: begin
                        tw_addr = {k, 1'b0};
                        src_tw  = 1'b1;
                        we      = !first_bf;
                        wr_addr = first_bf ? '0 : {b_prev_q, 1'b1};
                    end
                    3'd2: rd_addr = {b_pt, 1'b1};
                    3'd3: begin
                        tw_addr = {k, 1'b1};
                        src_tw  = 1'b1;
                    end
                    3'd4: rd_addr = {a_pt, 1'b0};
                    3'd5: rd_addr = {a_pt, 1'b1};
                    3'd6: begin
                        we      = 1'b1;
                        wr_addr = {a_pt, 1'b0};
                    end
                    3'd7: begin
                        we      = 1'b1;
                        wr_addr = {a_pt, 1'b1};
                    end
                    default: ;
                endcase
            end
            ST_FLUSH: begin
                we      = 1'b1;
                wr_addr = {b_prev_q, c_q[0]};
            end
            default: ;
        endcase
    end

    assign c_output_tri = ~we;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done         = (state_q == ST_DONE);
    assign bf_reset     = xReset || (state_q == ST_DONE);

endmodule

// File: doc/fft16_agu.md
# fft16_agu

Address generator and sequencer for the 16-point radix-2 decimation-in-time FFT datapath. It drives the in-place data RAM and the twiddle ROM so the butterfly unit receives operands in its fixed 8-cycle order (br, wr, bi, wi, ar, ai). It also commits the butterfly results back to RAM and starts, tristates and resets the butterfly. One xStart runs all 4 stages × 8 butterflies back-to-back with no bubbles, then signals done.

## Interface
- LOG2N, 4, log2 of FFT size; only 4 is supported and verified.
- xClock  in  1  system clock, all logic on rising edge.
- xReset  in  1  synchronous, active-high reset.
- xStart  in  1  start request, sampled only in IDLE.
- rd_addr  out  5  data RAM read address {point[3:0], im}; im=0 real, im=1 imag.
- tw_addr  out  4  twiddle ROM address {k[2:0], im}, W16^k.
- src_tw  out  1  butterfly xInput mux: 1 = twiddle ROM, 0 = data RAM.
- wr_addr  out  5  data RAM write address {point, im}.
- we  out  1  data RAM write enable; RAM writes butterfly xtriOutput at the edge ending the cycle.
- c_output_tri  out  1  butterfly output tristate control, equal to ~we.
- bf_start  out  1  butterfly xStart, one-cycle pulse.
- bf_reset  out  1  butterfly xReset.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle completion pulse.

## Operation
- Data RAM and twiddle ROM have asynchronous reads. The address is presented in cycle c, and the butterfly samples it at the edge ending c.
- The input is preloaded in bit-reversed order. The output is left in natural order, in place, and scaled by 1/16 (the butterfly halves per stage).
- State registers: state, stage s (2b), butterfly j (3b), slot cycle c (3b), b_prev (4b). All outputs decode combinationally from these (Moore).
- States:
  - IDLE: xStart → RUN, with s=j=c=0.
  - RUN: c increments every cycle. When c=7, j increments. When j=7 and c=7, s increments. When s=3, j=7 and c=7, go to FLUSH.
  - FLUSH: 2 cycles, fl=0 then fl=1, then go to DONE.
  - DONE: 1 cycle, then go to IDLE.
- Per butterfly: span=2^s; a = (j>>s)·2·span + (j mod span); b = a+span; k = (j mod span)<<(3−s). All arithmetic is 4-bit unsigned, with no overflow for LOG2N=4.
- Read schedule in RUN, per cycle c:
  - c=0: rd_addr={b,0}, src_tw=0.
  - c=1: tw_addr={k,0}, src_tw=1.
  - c=2: rd_addr={b,1}, src_tw=0.
  - c=3: tw_addr={k,1}, src_tw=1.
  - c=4: rd_addr={a,0}, src_tw=0.
  - c=5: rd_addr={a,1}, src_tw=0.
  - c=6,7: rd_addr=0, src_tw=0.
  - tw_addr is 0 whenever it is not in use.
- Write schedule (butterfly output order r1r, r1i, r2r, r2i):
  - c=6: we=1, wr_addr={a,0}.
  - c=7: we=1, wr_addr={a,1}.
  - c=0 of the next butterfly, or FLUSH fl=0: we=1, wr_addr={b_prev,0}.
  - c=1 of the next butterfly, or FLUSH fl=1: we=1, wr_addr={b_prev,1}.
  - b_prev loads b at c=7.
  - c=0 and c=1 of the very first butterfly (s=0, j=0): we=0.
- bf_start=1 only in RUN with s=0, j=0, c=0. The butterfly free-runs afterwards, and its count tracks c.
- bf_reset = xReset | (state==DONE), which returns the butterfly to idle.
- Hazards: butterflies within a stage touch disjoint points. Stage-boundary reads never hit a pending write: the last butterfly of each stage touches points 15 and 14, 13 or 11, while the first butterfly of the next stage reads 0 and span. No stall logic.
- xStart is ignored outside IDLE.

## Timing
- Reset values: state IDLE, all counters 0; rd_addr 0, tw_addr 0, wr_addr 0, src_tw 0, we 0, c_output_tri 1, bf_start 0, busy 0, done 0, bf_reset 1 while xReset is high.
- xStart sampled high in cycle T: RUN c=0 occurs in cycle T+1, and bf_start is high in T+1.
- RUN lasts 256 cycles (T+1..T+256). FLUSH is T+257..T+258. done=1 and bf_reset=1 in T+259. IDLE in T+260, when a new xStart is accepted.
- xReset in any state returns everything to reset values at the next edge, with no partial write (we=0 from that cycle on).
- xReset and xStart in the same cycle: reset wins.

## Test plan
- Reset: hold xReset 3 cycles → all outputs at reset values, c_output_tri=1, bf_reset=1, busy=0.
- Stage 0, butterfly 0: xStart at T → T+1..T+6 show rd 2, tw 0, rd 3, tw 1, rd 0, rd 1, with src_tw 0,1,0,1,0,0. bf_start only in T+1. we=0 in T+1..T+2. Writes go to 0 and 1 in T+7 and T+8, then to 2 and 3 in T+9 and T+10.
- Stage 2, butterfly 5 (a=9, b=13, k=2): reads 26, tw 4, 27, tw 5, 18, 19. Writes 18 and 19 at c=6,7, then 26 and 27 at c=0,1 of butterfly 6.
- Full run: done pulses exactly at T+259 together with bf_reset. FLUSH writes 30 then 31. busy is high for T+1..T+258. Total we-high cycles = 128.
- Robustness: xStart pulsed at T+50 is ignored (done timing unchanged). xReset at T+100 → idle next cycle with we=0. A restart afterwards completes normally.
- Integration with the butterfly unit and RAM model: impulse x[0]=0x4000, rest 0 → all 16 outputs real 0x0400 ±2 LSB, imag 0 ±2 LSB.
